// File: rtl/seizure_decision.sv
// Seizure alarm decision stage: sliding label history with count hysteresis and a refractory holdoff.
// Optional alarm episode counter enabled by defining SEIZURE_DECISION_STATS_EN.
module seizure_decision #(
    parameter int HISTORY         = 8,
    parameter int ON_THRESH       = 6,
    parameter int OFF_THRESH      = 2,
    parameter int HOLDOFF_WINDOWS = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             label_valid,
    input  logic                             label_in,
    output logic                             alarm,
    output logic                             alarm_onset,
    output logic [$clog2(HISTORY+1)-1:0]     ones_count,
    output logic                             history_full
`ifdef SEIZURE_DECISION_STATS_EN
    ,
    output logic [15:0]                      alarm_events
`endif
);

    localparam int CNT_W  = $clog2(HISTORY + 1);
    localparam int HOLD_W = (HOLDOFF_WINDOWS > 0) ? $clog2(HOLDOFF_WINDOWS + 1) : 1;

    if (HISTORY < 2) begin : g_bad_history
        $error("seizure_decision: HISTORY must be >= 2");
    end
    if (ON_THRESH <= OFF_THRESH || ON_THRESH > HISTORY) begin : g_bad_thresh
        $error("seizure_decision: require OFF_THRESH < ON_THRESH <= HISTORY");
    end

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        NORMAL  = 2'd1,
        ALARM   = 2'd2,
        HOLDOFF = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [HISTORY-1:0]  history, history_nxt;
    logic [CNT_W-1:0]    fill_cnt, fill_nxt;
    logic [CNT_W-1:0]    count_nxt, ones_nxt;
    logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
    logic                full_nxt, alarm_nxt, onset_nxt;
    logic                drop, above_on, below_off;

    // Incoming label count; before the history fills the oldest slot is empty, so nothing drops.
    always_comb begin
        drop      = history_full & history[HISTORY-1];
        count_nxt = ones_count + CNT_W'(label_in) - CNT_W'(drop);
        above_on  = (count_nxt >= CNT_W'(ON_THRESH));
        below_off = (count_nxt <= CNT_W'(OFF_THRESH));
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_nxt   = state;
        history_nxt = history;
        ones_nxt    = ones_count;
        fill_nxt    = fill_cnt;
        hold_nxt    = hold_cnt;
        full_nxt    = history_full;
        alarm_nxt   = alarm;
        onset_nxt   = 1'b0;

        if (label_valid) begin
            history_nxt = {history[HISTORY-2:0], label_in};
            ones_nxt    = count_nxt;
            unique case (state)
                FILL: begin
                    fill_nxt = fill_cnt + 1'b1;
                    if (fill_cnt == CNT_W'(HISTORY - 1)) begin
                        full_nxt = 1'b1;
                        if (above_on) begin
                            state_nxt = ALARM;
                            alarm_nxt = 1'b1;
                            onset_nxt = 1'b1;
                        end else begin
                            state_nxt = NORMAL;
                        end
                    end
                end
                NORMAL: begin
                    if (above_on) begin
                        state_nxt = ALARM;
                        alarm_nxt = 1'b1;
                        onset_nxt = 1'b1;
                    end
                end
                ALARM: begin
                    if (below_off) begin
                        alarm_nxt = 1'b0;
                        if (HOLDOFF_WINDOWS == 0) begin
                            state_nxt = NORMAL;
                        end else begin
                            state_nxt = HOLDOFF;
                            hold_nxt  = HOLD_W'(HOLDOFF_WINDOWS);
                        end
                    end
                end
                HOLDOFF: begin
                    // Thresholds are deliberately ignored here, even on the exit edge.
                    hold_nxt = hold_cnt - 1'b1;
                    if (hold_cnt == HOLD_W'(1)) begin
                        state_nxt = NORMAL;
                    end
                end
                default: state_nxt = FILL;
            endcase
        end
    end

    // NOTE: non-blocking assignments for all registered state so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the history is a plain shift register, not a memory, so it is reset with the rest.
            state        <= FILL;
            history      <= '0;
            ones_count   <= '0;
            fill_cnt     <= '0;
            hold_cnt     <= '0;
            history_full <= 1'b0;
            alarm        <= 1'b0;
            alarm_onset  <= 1'b0;
        end else begin
            state        <= state_nxt;
            history      <= history_nxt;
            ones_count   <= ones_nxt;
            fill_cnt     <= fill_nxt;
            hold_cnt     <= hold_nxt;
            history_full <= full_nxt;
            alarm        <= alarm_nxt;
            alarm_onset  <= onset_nxt;
        end
    end

`ifdef SEIZURE_DECISION_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            alarm_events <= '0;
        end else if (onset_nxt && alarm_events != 16'hFFFF) begin
            alarm_events <= alarm_events + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_seizure_decision.sv
// Self-checking bench for seizure_decision: directed scenarios plus random label streams
// compared against a queue-based behavioural model.
module tb_seizure_decision;

    localparam int HISTORY         = 8;
    localparam int ON_THRESH       = 6;
    localparam int OFF_THRESH      = 2;
    localparam int HOLDOFF_WINDOWS = 4;
    localparam int CNT_W           = $clog2(HISTORY + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             label_valid = 1'b0;
    logic             label_in = 1'b0;
    logic             alarm, alarm_onset, history_full;
    logic [CNT_W-1:0] ones_count;
`ifdef SEIZURE_DECISION_STATS_EN
    logic [15:0]      alarm_events;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_hist[$];
    int m_alarm, m_onset, m_full, m_hold, m_events;

    always #5 clk = ~clk;

    seizure_decision #(
        .HISTORY(HISTORY), .ON_THRESH(ON_THRESH),
        .OFF_THRESH(OFF_THRESH), .HOLDOFF_WINDOWS(HOLDOFF_WINDOWS)
    ) dut (
        .clk(clk), .rst(rst), .label_valid(label_valid), .label_in(label_in),
        .alarm(alarm), .alarm_onset(alarm_onset),
        .ones_count(ones_count), .history_full(history_full)
`ifdef SEIZURE_DECISION_STATS_EN
        , .alarm_events(alarm_events)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_count();
        int s = 0;
        foreach (m_hist[i]) s += m_hist[i];
        return s;
    endfunction

    task automatic model_reset();
        m_hist.delete();
        m_alarm = 0; m_onset = 0; m_full = 0; m_hold = 0; m_events = 0;
    endtask

    // Rule-level model: window of the last HISTORY labels, hysteresis on its sum, holdoff in labels.
    task automatic model_label(input int lbl);
        int cnt;
        m_hist.push_back(lbl);
        if (m_hist.size() > HISTORY) void'(m_hist.pop_front());
        cnt     = m_count();
        m_onset = 0;
        if (!m_full) begin
            if (m_hist.size() == HISTORY) begin
                m_full = 1;
                if (cnt >= ON_THRESH) begin m_alarm = 1; m_onset = 1; end
            end
        end else if (m_hold > 0) begin
            m_hold--;
        end else if (m_alarm) begin
            if (cnt <= OFF_THRESH) begin m_alarm = 0; m_hold = HOLDOFF_WINDOWS; end
        end else if (cnt >= ON_THRESH) begin
            m_alarm = 1; m_onset = 1;
        end
        if (m_onset && m_events < 65535) m_events++;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".alarm"}, 32'(alarm), 32'(m_alarm));
        check({tag, ".onset"}, 32'(alarm_onset), 32'(m_onset));
        check({tag, ".count"}, 32'(ones_count), 32'(m_count()));
        check({tag, ".full"},  32'(history_full), 32'(m_full));
`ifdef SEIZURE_DECISION_STATS_EN
        check({tag, ".events"}, 32'(alarm_events), 32'(m_events));
`endif
    endtask

    // One clock: drive on the falling edge, update model at the rising edge, sample 1 ns later.
    task automatic step(input string tag, input bit v, input bit lbl, input bit r);
        @(negedge clk);
        rst = r; label_valid = v; label_in = lbl;
        @(posedge clk);
        if (r)      model_reset();
        else if (v) model_label(int'(lbl));
        else        m_onset = 0;
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset();
        step("rst", 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0; label_valid = 1'b0;
    endtask

    task automatic feed(input string tag, input int n, input bit lbl);
        for (int i = 0; i < n; i++) step(tag, 1'b1, lbl, 1'b0);
    endtask

    initial begin
        int max_cnt, clear_cnt, guard, p;
        bit saved_full, saved_alarm;
        logic [CNT_W-1:0] saved_cnt;

        model_reset();
        do_reset();
        check("reset.alarm", 32'(alarm), 32'd0);
        check("reset.count", 32'(ones_count), 32'd0);
        check("reset.full", 32'(history_full), 32'd0);

        // 8 ones at one strobe per 3 cycles
        for (int i = 1; i <= HISTORY; i++) begin
            step("fill1", 1'b1, 1'b1, 1'b0);
            check("fill1.count_n", 32'(ones_count), 32'(i));
            check("fill1.alarm_n", 32'(alarm), (i == HISTORY) ? 32'd1 : 32'd0);
            if (i == HISTORY) begin
                check("fill1.full8", 32'(history_full), 32'd1);
                check("fill1.onset8", 32'(alarm_onset), 32'd1);
            end
            step("fill1.gap", 1'b0, 1'b1, 1'b0);
            if (i == HISTORY) check("fill1.onset_pulse", 32'(alarm_onset), 32'd0);
            step("fill1.gap", 1'b0, 1'b0, 1'b0);
        end

        // Zeros then alternating labels never reach ON_THRESH
        do_reset();
        feed("alt.zeros", HISTORY, 1'b0);
        max_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step("alt", 1'b1, 1'(i % 2 == 0), 1'b0);
            if (int'(ones_count) > max_cnt) max_cnt = int'(ones_count);
        end
        check("alt.max_le4", 32'(max_cnt <= 4), 32'd1);
        check("alt.alarm", 32'(alarm), 32'd0);

        // Alarm, decay to OFF_THRESH, holdoff, re-arm
        do_reset();
        feed("hyst.ones", HISTORY, 1'b1);
        clear_cnt = -1;
        for (int i = 0; i < HISTORY && clear_cnt < 0; i++) begin
            step("hyst.decay", 1'b1, 1'b0, 1'b0);
            if (!alarm) clear_cnt = int'(ones_count);
        end
        check("hyst.clear_at", 32'(clear_cnt), 32'(OFF_THRESH));
        for (int i = 0; i < HOLDOFF_WINDOWS - 1; i++) begin
            step("hold", 1'b1, 1'b1, 1'b0);
            check("hold.noalarm", 32'(alarm), 32'd0);
        end
        step("hold.exit", 1'b1, 1'b1, 1'b0);
        check("hold.exit_noalarm", 32'(alarm), 32'd0);
        guard = 0;
        while (!alarm && guard < HISTORY) begin
            step("rearm", 1'b1, 1'b1, 1'b0);
            guard++;
        end
        check("rearm.alarm", 32'(alarm), 32'd1);
        check("rearm.onset", 32'(alarm_onset), 32'd1);
        check("rearm.count_ge_on", 32'(ones_count >= CNT_W'(ON_THRESH)), 32'd1);

        // Idle stretch mid-fill
        do_reset();
        feed("idle.pre", 3, 1'b1);
        saved_cnt = ones_count; saved_full = history_full; saved_alarm = alarm;
        for (int i = 0; i < 50; i++) step("idle", 1'b0, 1'(i % 2), 1'b0);
        check("idle.count", 32'(ones_count), 32'(saved_cnt));
        check("idle.full", 32'(history_full), 32'(saved_full));
        check("idle.alarm", 32'(alarm), 32'(saved_alarm));

        // Reset beats a coincident valid label
        feed("rstv.ones", HISTORY, 1'b1);
        check("rstv.pre_alarm", 32'(alarm), 32'd1);
        step("rstv", 1'b1, 1'b1, 1'b1);
        check("rstv.alarm", 32'(alarm), 32'd0);
        check("rstv.count", 32'(ones_count), 32'd0);
        check("rstv.full", 32'(history_full), 32'd0);
        @(negedge clk);
        rst = 1'b0; label_valid = 1'b0;

`ifdef SEIZURE_DECISION_STATS_EN
        do_reset();
        for (int e = 0; e < 3; e++) begin
            feed("stats.on", HISTORY, 1'b1);
            feed("stats.off", HISTORY + HOLDOFF_WINDOWS, 1'b0);
        end
        check("stats.three", 32'(alarm_events), 32'd3);
        @(negedge clk);
        force dut.alarm_events = 16'hFFFE;
        @(negedge clk);
        release dut.alarm_events;
        m_events = 65534;
        for (int e = 0; e < 2; e++) begin
            feed("stats.sat_on", HISTORY, 1'b1);
            feed("stats.sat_off", HISTORY + HOLDOFF_WINDOWS, 1'b0);
        end
        check("stats.saturate", 32'(alarm_events), 32'hFFFF);
`endif

        // Random label streams with drifting bias and rare resets
        do_reset();
        p = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 30 == 0) p = (($urandom % 3) == 0) ? 10 : (($urandom % 2) == 0) ? 50 : 90;
            step("rand", 1'(($urandom % 100) < 60), 1'(($urandom % 100) < p),
                 1'(($urandom % 500) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
